// File: rtl/mem_request_queue.sv
`default_nettype none
// ============================================================================
//  Module      : mem_request_queue
//  Description : In-order request buffer between the trace parser and the DRAM
//                command scheduler. Holds DEPTH requests (op + address), keeps
//                a saturating age for every resident entry, presents the oldest
//                entry over valid/ready and counts requests dropped when full.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_request_queue #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 33,
   parameter int AGE_W  = 8,
   parameter int DROP_W = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   input  logic [1:0]                   in_op,
   input  logic [ADDR_W-1:0]            in_addr,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [1:0]                   out_op,
   output logic [ADDR_W-1:0]            out_addr,
   output logic [AGE_W-1:0]             out_age,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty,
   output logic                         drop_pulse,
   output logic [DROP_W-1:0]            drop_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0]     C_DEPTH    = CW'(DEPTH);
   localparam logic [AGE_W-1:0]  C_AGE_MAX  = {AGE_W{1'b1}};
   localparam logic [DROP_W-1:0] C_DROP_MAX = {DROP_W{1'b1}};
   localparam logic [1:0]        C_OP_NOP   = 2'd3;

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              drop_pulse_q, drop_pulse_d;
   logic [DROP_W-1:0] drop_count_q, drop_count_d;

   logic              w_req;
   logic              w_enq;
   logic              w_deq;
   logic              w_drop;

   logic [1:0]        w_op   [DEPTH];
   logic [ADDR_W-1:0] w_addr [DEPTH];
   logic [AGE_W-1:0]  w_age  [DEPTH];

   // NOP ops are neither stored nor counted as drops; full blocks enqueue even
   // when the head is leaving in the same cycle (no full bypass).
   assign w_req  = in_valid && (in_op != C_OP_NOP);
   assign w_enq  = w_req && !full_q;
   assign w_drop = w_req && full_q;
   assign w_deq  = !empty_q && out_ready;

   // Per-entry storage. An entry is resident when its distance from the read
   // pointer is below the occupancy count; only resident entries age.
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [1:0]        op_q;
      logic [ADDR_W-1:0] addr_q;
      logic [AGE_W-1:0]  age_q;
      logic [PW-1:0]     w_rel;
      logic              w_occupied;

      assign w_rel      = PW'(i) - rd_ptr_q;
      assign w_occupied = (CW'(w_rel) < count_q);

      // Capture a new request into this slot, otherwise advance its age.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            op_q   <= '0;
            addr_q <= '0;
            age_q  <= '0;
         end else if (w_enq && (wr_ptr_q == PW'(i))) begin
            op_q   <= in_op;
            addr_q <= in_addr;
            age_q  <= '0;
         end else if (w_occupied && (age_q != C_AGE_MAX)) begin
            age_q  <= age_q + AGE_W'(1);
         end
      end

      assign w_op[i]   = op_q;
      assign w_addr[i] = addr_q;
      assign w_age[i]  = age_q;
   end

   // Next-state for pointers, occupancy flags and drop accounting.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      drop_pulse_d = w_drop;
      drop_count_d = drop_count_q;

      if (w_enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (w_deq) rd_ptr_d = rd_ptr_q + PW'(1);

      case ({w_enq, w_deq})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (w_drop && (drop_count_q != C_DROP_MAX))
         drop_count_d = drop_count_q + DROP_W'(1);

      full_d  = (count_d == C_DEPTH);
      empty_d = (count_d == '0);
   end

   // Control state register; reset discards every entry at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         drop_pulse_q <= 1'b0;
         drop_count_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         full_q       <= full_d;
         empty_q      <= empty_d;
         drop_pulse_q <= drop_pulse_d;
         drop_count_q <= drop_count_d;
      end
   end

   // Head fields are forced to zero whenever nothing is resident.
   assign out_valid  = !empty_q;
   assign out_op     = out_valid ? w_op[rd_ptr_q]   : '0;
   assign out_addr   = out_valid ? w_addr[rd_ptr_q] : '0;
   assign out_age    = out_valid ? w_age[rd_ptr_q]  : '0;
   assign in_ready   = !full_q;
   assign count      = count_q;
   assign full       = full_q;
   assign empty      = empty_q;
   assign drop_pulse = drop_pulse_q;
   assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_request_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_request_queue
//  Description : Directed self-checking bench for mem_request_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_request_queue;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 33;
   localparam int AGE_W  = 8;
   localparam int DROP_W = 16;
   localparam int CW     = $clog2(DEPTH+1);

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic [1:0]        in_op;
   logic [ADDR_W-1:0] in_addr;
   logic              in_ready;
   logic              out_valid;
   logic [1:0]        out_op;
   logic [ADDR_W-1:0] out_addr;
   logic [AGE_W-1:0]  out_age;
   logic              out_ready;
   logic [CW-1:0]     count;
   logic              full;
   logic              empty;
   logic              drop_pulse;
   logic [DROP_W-1:0] drop_count;

   int checks;
   int failures;

   mem_request_queue #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .AGE_W  (AGE_W),
      .DROP_W (DROP_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_op      (in_op),
      .in_addr    (in_addr),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_op     (out_op),
      .out_addr   (out_addr),
      .out_age    (out_age),
      .out_ready  (out_ready),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .drop_pulse (drop_pulse),
      .drop_count (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 2'd0;
      in_addr   = '0;
      out_ready = 1'b0;
      repeat (2) step();

      // Reset state
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_drop_pulse", 64'(drop_pulse), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_drop_count", 64'(drop_count), 64'd0);
      chk("rst_out_addr", 64'(out_addr), 64'd0);
      chk("rst_out_op", 64'(out_op), 64'd0);
      chk("rst_out_age", 64'(out_age), 64'd0);
      rst_n = 1'b1;
      step();

      // 1: single enqueue, latency and aging
      in_valid = 1'b1; in_op = 2'd0; in_addr = 33'h1_0000_0040;
      step();
      in_valid = 1'b0;
      chk("t1_out_valid", 64'(out_valid), 64'd1);
      chk("t1_out_addr", 64'(out_addr), 64'h1_0000_0040);
      chk("t1_out_age0", 64'(out_age), 64'd0);
      chk("t1_count", 64'(count), 64'd1);
      repeat (5) step();
      chk("t1_out_age5", 64'(out_age), 64'd5);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t1_empty", 64'(empty), 64'd1);

      // 2: fill, drop when full, drain in order
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_op = 2'(i % 3); in_addr = 33'(64'h100 + 4 * i);
         step();
      end
      chk("t2_full", 64'(full), 64'd1);
      chk("t2_in_ready", 64'(in_ready), 64'd0);
      chk("t2_count", 64'(count), 64'd16);
      chk("t2_head_age", 64'(out_age), 64'd15);
      in_op = 2'd1; in_addr = 33'h0_0000_DEAD;
      step();
      in_valid = 1'b0;
      chk("t2_drop_pulse", 64'(drop_pulse), 64'd1);
      chk("t2_drop_count", 64'(drop_count), 64'd1);
      chk("t2_count_kept", 64'(count), 64'd16);
      chk("t2_head_kept", 64'(out_addr), 64'h100);
      step();
      chk("t2_drop_pulse_off", 64'(drop_pulse), 64'd0);
      // Full with simultaneous dequeue: the new request must still be dropped.
      in_valid = 1'b1; in_op = 2'd2; in_addr = 33'h0_0000_BEEF; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("t2_nobypass_count", 64'(count), 64'd15);
      chk("t2_nobypass_drop", 64'(drop_count), 64'd2);
      chk("t2_nobypass_pulse", 64'(drop_pulse), 64'd1);
      for (int i = 1; i < 16; i++) begin
         chk("t2_drain_valid", 64'(out_valid), 64'd1);
         chk("t2_drain_addr", 64'(out_addr), 64'h100 + 64'(4 * i));
         chk("t2_drain_op", 64'(out_op), 64'(i % 3));
         step();
      end
      out_ready = 1'b0;
      chk("t2_empty", 64'(empty), 64'd1);
      chk("t2_out_valid0", 64'(out_valid), 64'd0);
      chk("t2_out_addr0", 64'(out_addr), 64'd0);
      chk("t2_out_op0", 64'(out_op), 64'd0);

      // 3: steady count=3 streaming across pointer wrap
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_op = 2'd1; in_addr = 33'(64'h2000 + k);
         step();
      end
      for (int j = 0; j < 40; j++) begin
         in_valid = 1'b1; in_op = 2'd0; in_addr = 33'(64'h2000 + 3 + j); out_ready = 1'b1;
         chk("t3_head", 64'(out_addr), 64'h2000 + 64'(j));
         step();
         chk("t3_count", 64'(count), 64'd3);
      end
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("t3_tail", 64'(out_addr), 64'h2000 + 64'(40 + k));
         step();
      end
      out_ready = 1'b0;
      chk("t3_empty", 64'(empty), 64'd1);

      // 4: NOPs are neither queued nor dropped
      in_valid = 1'b1; in_op = 2'd3; in_addr = 33'h0_0000_1234;
      repeat (10) step();
      in_valid = 1'b0;
      chk("t4_count", 64'(count), 64'd0);
      chk("t4_drop_count", 64'(drop_count), 64'd2);
      chk("t4_out_valid", 64'(out_valid), 64'd0);

      // 5: age saturation
      in_valid = 1'b1; in_op = 2'd2; in_addr = 33'h0_0000_5000;
      step();
      in_valid = 1'b0;
      repeat (254) step();
      chk("t5_age254", 64'(out_age), 64'd254);
      step();
      chk("t5_age255", 64'(out_age), 64'd255);
      repeat (45) step();
      chk("t5_age_sat", 64'(out_age), 64'd255);

      // 6: asynchronous reset mid-operation
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1; in_op = 2'd0; in_addr = 33'(64'h6000 + k);
         step();
      end
      in_valid = 1'b0;
      chk("t6_count7", 64'(count), 64'd7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
      chk("t6_rst_count", 64'(count), 64'd0);
      chk("t6_rst_empty", 64'(empty), 64'd1);
      chk("t6_rst_drop_count", 64'(drop_count), 64'd0);
      chk("t6_rst_out_age", 64'(out_age), 64'd0);
      #1;
      rst_n = 1'b1;
      step();
      in_valid = 1'b1; in_op = 2'd2; in_addr = 33'h1_2345_6789;
      step();
      in_valid = 1'b0;
      chk("t6_new_valid", 64'(out_valid), 64'd1);
      chk("t6_new_addr", 64'(out_addr), 64'h1_2345_6789);
      chk("t6_new_op", 64'(out_op), 64'd2);
      chk("t6_new_count", 64'(count), 64'd1);
      chk("t6_new_age", 64'(out_age), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
